// File: rtl/vga_bounce_sprite.sv
// vga_bounce_sprite: draws a bouncing, colour-cycling box behind the VGA sync generator.
// Define SCREEN_BORDER_EN to overlay a white one-pixel border around the visible area.
module vga_bounce_sprite #(
  parameter int H_DISPLAY = 640,
  parameter int V_DISPLAY = 480,
  parameter int BOX_W     = 32,
  parameter int BOX_H     = 32,
  parameter int SPEED     = 2,
  parameter int X0        = 100,
  parameter int Y0        = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       pause,
  output logic [1:0] r,
  output logic [1:0] g,
  output logic [1:0] b,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       frame_tick,
  output logic [7:0] bounce_cnt
);
  localparam logic [10:0] X_MAX = 11'(H_DISPLAY - BOX_W);
  localparam logic [10:0] Y_MAX = 11'(V_DISPLAY - BOX_H);
  localparam logic [10:0] SPD   = 11'(SPEED);
  logic [9:0]  r_box_x, r_box_y;
  logic        r_left, r_up;
  logic [2:0]  r_colour;
  logic        w_tick, w_bx, w_by, w_inside, w_border;
  logic [10:0] w_x, w_y, w_h, w_v;
  logic [9:0]  w_nx, w_ny;
  logic [5:0]  w_rgb;
  // 11-bit compares keep box+SPEED and box+BOX from wrapping
  always_comb begin
    w_x      = {1'b0, r_box_x};
    w_y      = {1'b0, r_box_y};
    w_h      = {1'b0, hpos};
    w_v      = {1'b0, vpos};
    w_tick   = hpos == '0 && vpos == 10'(V_DISPLAY);
    w_bx     = r_left ? w_x <= SPD : w_x + SPD >= X_MAX;
    w_by     = r_up   ? w_y <= SPD : w_y + SPD >= Y_MAX;
    w_nx     = w_bx ? (r_left ? '0 : X_MAX[9:0]) : (r_left ? r_box_x - SPD[9:0] : r_box_x + SPD[9:0]);
    w_ny     = w_by ? (r_up ? '0 : Y_MAX[9:0]) : (r_up ? r_box_y - SPD[9:0] : r_box_y + SPD[9:0]);
    w_inside = display_on && w_h >= w_x && w_h < w_x + 11'(BOX_W) && w_v >= w_y && w_v < w_y + 11'(BOX_H);
`ifdef SCREEN_BORDER_EN
    w_border = display_on && (hpos == '0 || hpos == 10'(H_DISPLAY - 1) || vpos == '0 || vpos == 10'(V_DISPLAY - 1));
`else
    w_border = 1'b0;
`endif
    w_rgb    = w_border ? '1 : w_inside ? {{2{r_colour[2]}}, {2{r_colour[1]}}, {2{r_colour[0]}}} : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {r, g, b}  <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      frame_tick <= 1'b0;
      bounce_cnt <= '0;
      r_box_x    <= 10'(X0);
      r_box_y    <= 10'(Y0);
      r_left     <= 1'b0;
      r_up       <= 1'b0;
      r_colour   <= 3'd1;
    end else begin
      {r, g, b}  <= w_rgb;
      hsync_out  <= hsync_in;
      vsync_out  <= vsync_in;
      frame_tick <= w_tick;
      if (w_tick && !pause) begin
        r_box_x <= w_nx;
        r_box_y <= w_ny;
        r_left  <= r_left ^ w_bx;
        r_up    <= r_up ^ w_by;
        if (w_bx || w_by) begin
          r_colour   <= r_colour == 3'd7 ? 3'd1 : r_colour + 3'd1;
          bounce_cnt <= bounce_cnt + 8'd1;
        end
      end
    end
  end
endmodule
